// File: rtl/fust_issue_sched.sv
// -----------------------------------------------------------------------------
// fust_issue_sched
//   Per-functional-unit issue scheduler. One status entry per FU holds a state
//   (IDLE/WAIT/READY/ISSUED) and two operand dependency tags. Writeback
//   broadcasts clear matching tags; a round-robin arbiter grants one READY
//   entry per cycle to execute over a valid/ready handshake.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   flush           squash all WAIT/READY entries (ISSUED stay in flight)
//   freeze          stall dispatch accept and issue (wakeup/completion go on)
//   disp_*          dispatch request: target FU, operand tags; disp_ready out
//   wb_valid/wb_tag writeback broadcast of a completed tag (tag 0 = none)
//   fu_done         per-FU completion pulse, retires an ISSUED entry
//   issue_valid/issue_fu/issue_ready   grant handshake towards execute
//   entry_state     packed per-entry state, entry i at [2i+1:2i]
//
// Optional feature (macro FUST_ISSUE_SCHED_PERF_EN):
//   perf_issued     saturating count of completed issue handshakes
//   perf_starved    saturating count of cycles with a WAIT entry and no grant
// -----------------------------------------------------------------------------
module fust_issue_sched #(
    parameter int NUM_FU = 5,
    parameter int FUW    = 3,
    parameter int TW     = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                flush,
    input  logic                freeze,
    input  logic                disp_valid,
    input  logic [FUW-1:0]      disp_fu,
    input  logic [TW-1:0]       disp_t1,
    input  logic [TW-1:0]       disp_t2,
    output logic                disp_ready,
    input  logic                wb_valid,
    input  logic [TW-1:0]       wb_tag,
    input  logic [NUM_FU-1:0]   fu_done,
    output logic                issue_valid,
    output logic [FUW-1:0]      issue_fu,
    input  logic                issue_ready,
`ifdef FUST_ISSUE_SCHED_PERF_EN
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_starved,
`endif
    output logic [2*NUM_FU-1:0] entry_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } state_e;

    state_e          state_q [NUM_FU];
    state_e          state_d [NUM_FU];
    logic [TW-1:0]   t1_q    [NUM_FU];
    logic [TW-1:0]   t1_d    [NUM_FU];
    logic [TW-1:0]   t2_q    [NUM_FU];
    logic [TW-1:0]   t2_d    [NUM_FU];
    logic [FUW-1:0]  ptr_q;
    logic [FUW-1:0]  ptr_d;

    logic            any_ready;
    logic [FUW-1:0]  grant_fu;
    logic [FUW:0]    cand;
    logic            hit;
    logic            handshake;
    logic            disp_accept;
    logic [TW-1:0]   disp_t1_eff;
    logic [TW-1:0]   disp_t2_eff;
    logic            wb_live;

    // Dispatch acceptance: target must exist, be IDLE, and no stall/squash.
    always_comb begin
        disp_ready = 1'b0;
        if (!freeze && !flush && (32'(disp_fu) < NUM_FU)) begin
            disp_ready = (state_q[disp_fu] == ST_IDLE);
        end else begin
            disp_ready = 1'b0;
        end
    end

    // Round-robin search: first READY entry at or after the pointer (wrapping).
    always_comb begin
        any_ready = 1'b0;
        grant_fu  = '0;
        cand      = '0;
        hit       = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand      = {1'b0, ptr_q} + (FUW+1)'(k);
            cand      = (cand >= (FUW+1)'(NUM_FU)) ? (cand - (FUW+1)'(NUM_FU)) : cand;
            hit       = !any_ready && (state_q[cand[FUW-1:0]] == ST_READY);
            grant_fu  = hit ? cand[FUW-1:0] : grant_fu;
            any_ready = any_ready | hit;
        end
    end

    assign issue_valid = !freeze && !flush && any_ready;
    assign issue_fu    = grant_fu;
    assign handshake   = issue_valid && issue_ready;
    assign disp_accept = disp_valid && disp_ready;
    assign wb_live     = wb_valid && (wb_tag != {TW{1'b0}});

    // A tag completing in the dispatch cycle never becomes a dependency.
    assign disp_t1_eff = (wb_valid && (disp_t1 == wb_tag)) ? {TW{1'b0}} : disp_t1;
    assign disp_t2_eff = (wb_valid && (disp_t2 == wb_tag)) ? {TW{1'b0}} : disp_t2;

    // Pointer moves past the granted entry only on an accepted grant.
    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (grant_fu == FUW'(NUM_FU - 1)) ? {FUW{1'b0}} : (grant_fu + FUW'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Per-entry next state; each state reacts only to its own events, and
    // flush overrides WAIT/READY last.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            state_d[i] = state_q[i];
            t1_d[i]    = t1_q[i];
            t2_d[i]    = t2_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (disp_accept && (disp_fu == FUW'(i))) begin
                        t1_d[i]    = disp_t1_eff;
                        t2_d[i]    = disp_t2_eff;
                        state_d[i] = ((disp_t1_eff == {TW{1'b0}}) && (disp_t2_eff == {TW{1'b0}}))
                                     ? ST_READY : ST_WAIT;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wb_live) begin
                        t1_d[i]    = (t1_q[i] == wb_tag) ? {TW{1'b0}} : t1_q[i];
                        t2_d[i]    = (t2_q[i] == wb_tag) ? {TW{1'b0}} : t2_q[i];
                        state_d[i] = ((t1_d[i] == {TW{1'b0}}) && (t2_d[i] == {TW{1'b0}}))
                                     ? ST_READY : ST_WAIT;
                    end else begin
                        state_d[i] = ST_WAIT;
                    end
                end
                ST_READY: begin
                    if (handshake && (grant_fu == FUW'(i))) begin
                        state_d[i] = ST_ISSUED;
                    end else begin
                        state_d[i] = ST_READY;
                    end
                end
                ST_ISSUED: begin
                    if (fu_done[i]) begin
                        state_d[i] = ST_IDLE;
                        t1_d[i]    = {TW{1'b0}};
                        t2_d[i]    = {TW{1'b0}};
                    end else begin
                        state_d[i] = ST_ISSUED;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
            if (flush && ((state_q[i] == ST_WAIT) || (state_q[i] == ST_READY))) begin
                state_d[i] = ST_IDLE;
                t1_d[i]    = {TW{1'b0}};
                t2_d[i]    = {TW{1'b0}};
            end else begin
                state_d[i] = state_d[i];
            end
        end
    end

    // Status table and pointer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= ST_IDLE;
                t1_q[i]    <= {TW{1'b0}};
                t2_q[i]    <= {TW{1'b0}};
            end
            ptr_q <= {FUW{1'b0}};
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= state_d[i];
                t1_q[i]    <= t1_d[i];
                t2_q[i]    <= t2_d[i];
            end
            ptr_q <= ptr_d;
        end
    end

    // Pack per-entry state for the status outputs.
    always_comb begin
        entry_state = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            entry_state[2*i +: 2] = state_q[i];
        end
    end

`ifdef FUST_ISSUE_SCHED_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_issued_d;
    logic [31:0] perf_starved_q;
    logic [31:0] perf_starved_d;
    logic        any_wait;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        any_wait = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            any_wait = any_wait | (state_q[i] == ST_WAIT);
        end
        perf_issued_d  = perf_issued_q;
        perf_starved_d = perf_starved_q;
        if (handshake && (perf_issued_q != 32'hFFFF_FFFF)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end else begin
            perf_issued_d = perf_issued_q;
        end
        if (any_wait && !issue_valid && (perf_starved_q != 32'hFFFF_FFFF)) begin
            perf_starved_d = perf_starved_q + 32'd1;
        end else begin
            perf_starved_d = perf_starved_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_issued_q  <= 32'd0;
            perf_starved_q <= 32'd0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_starved_q <= perf_starved_d;
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_starved = perf_starved_q;
`endif

endmodule
